// File: rtl/lut_buffer_if.sv
// LUT stream link between the upstream LUT source (master) and lut_buffer (slave).
interface lut_buffer_if #(
  parameter int unsigned DW = 8
) ();
  logic          start;
  logic [DW-1:0] ltdata;
  logic          ltvalid;
  logic          ltlast;
  logic          ltready;

  modport master (output ltdata, ltvalid, ltlast, input  start, ltready);
  modport slave  (input  ltdata, ltvalid, ltlast, output start, ltready);
endinterface

// File: rtl/lut_buffer.sv
// LUT consumer: requests a transfer, stores the signed entry stream, checks its
// length against DEPTH, then serves one-cycle-latency random-access reads.
module lut_buffer #(
  parameter int unsigned DEPTH = 160,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  output logic          loaded,
  output logic          err,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  lut_buffer_if.slave   lt
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned AW1 = AW + 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEPTH - 1);
  localparam logic [AW1-1:0] ADDR_LIM = AW1'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, LOAD, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic            start_q, start_d;
  logic            ltready_q, ltready_d;
  logic            loaded_q, loaded_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            mem_we;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   mem [DEPTH];

  assign wr_addr = AW'(wr_cnt_q);

  // Transfer control: next state, counter, status flags and table write enable.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    mem_we   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (load) begin
          state_d  = REQ;
          wr_cnt_d = '0;
          loaded_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      REQ: state_d = LOAD;
      LOAD: begin
        if (lt.ltvalid && ltready_q) begin
          // Overflow beats are accepted but neither stored nor counted past DEPTH.
          if (wr_cnt_q < CNT_MAX) begin
            mem_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
          if (lt.ltlast) begin
            state_d  = DONE;
            loaded_d = 1'b1;
            err_d    = (wr_cnt_q != CNT_LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) mem_we = 1'b0;

    start_d   = (state_d == REQ);
    ltready_d = (state_d == LOAD);
  end

  // Read port; out-of-range or not-yet-loaded reads return zero.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      if (loaded_q && ({1'b0, rd_addr} < ADDR_LIM)) rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      start_q    <= 1'b0;
      ltready_q  <= 1'b0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      start_q    <= start_d;
      ltready_q  <= ltready_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Table storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= lt.ltdata;
  end

  assign lt.start   = start_q;
  assign lt.ltready = ltready_q;
  assign loaded     = loaded_q;
  assign err        = err_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_lut_buffer.sv
// Self-checking bench for lut_buffer: transfer/flag checks plus a read scoreboard.
module tb_lut_buffer;

  localparam int unsigned DEPTH = 160;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;

  typedef struct {
    int unsigned   cyc;
    int            addr;
    logic [DW-1:0] data;
  } rd_item_t;

  logic          clk;
  logic          rst;
  logic          load;
  logic          loaded;
  logic          err;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  lut_buffer_if #(.DW(DW)) lt_if ();

  lut_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .loaded   (loaded),
    .err      (err),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .lt       (lt_if)
  );

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  int unsigned   cyc   = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_loaded = 1'b0;
  rd_item_t      sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input int kind, input int i);
    case (kind)
      0:       return DW'(i);
      1:       return DW'(8'hA5 ^ DW'(i));
      default: return DW'(255 - i);
    endcase
  endfunction

  // Read scoreboard: every issued read must come back exactly one cycle later.
  always @(negedge clk) begin
    rd_item_t item;
    if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      item = sb.pop_front();
      check("rd_valid", 32'(rd_valid), 32'd1);
      check($sformatf("rd_data[%0d]", item.addr), 32'(rd_data), 32'(item.data));
    end else if (rd_valid) begin
      check("rd_valid_extra", 32'(rd_valid), 32'd0);
    end
  end

  task automatic rd_issue(input int addr);
    rd_item_t item;
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    item.cyc  = cyc + 1;
    item.addr = addr;
    item.data = (m_loaded && addr < int'(DEPTH)) ? ref_mem[addr] : '0;
    sb.push_back(item);
    @(negedge clk);
  endtask

  task automatic rd_end();
    rd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic read_all();
    for (int i = 0; i < int'(DEPTH); i++) rd_issue(i);
    rd_end();
  endtask

  // Drives nbeats entries (ltlast on the final one unless no_last); stalls every third cycle.
  task automatic send_beats(input int nbeats, input int kind, input bit stall, input bit no_last,
                            output int miss);
    int sent = 0;
    int k = 0;
    miss = 0;
    while (sent < nbeats) begin
      if (stall && (k % 3 == 2)) begin
        lt_if.ltvalid = 1'b0;
        lt_if.ltlast  = 1'b0;
      end else begin
        if (!lt_if.ltready) miss++;
        lt_if.ltvalid = 1'b1;
        lt_if.ltdata  = data_of(kind, sent);
        lt_if.ltlast  = !no_last && (sent == nbeats - 1);
        if (sent < int'(DEPTH)) ref_mem[sent] = lt_if.ltdata;
        sent++;
      end
      k++;
      @(negedge clk);
    end
    lt_if.ltvalid = 1'b0;
    lt_if.ltlast  = 1'b0;
  endtask

  task automatic start_load(input string tag);
    load = 1'b1;
    m_loaded = 1'b0;
    @(negedge clk);
    load = 1'b0;
    check({tag, "_start"},      32'(lt_if.start),   32'd1);
    check({tag, "_ready_req"},  32'(lt_if.ltready), 32'd0);
    check({tag, "_loaded_clr"}, 32'(loaded),        32'd0);
    check({tag, "_err_clr"},    32'(err),           32'd0);
    @(negedge clk);
    check({tag, "_start_once"}, 32'(lt_if.start),   32'd0);
    check({tag, "_ready_load"}, 32'(lt_if.ltready), 32'd1);
  endtask

  task automatic xfer(input string tag, input int nbeats, input int kind, input bit stall,
                      input bit exp_err);
    int unsigned c0;
    int miss;
    c0 = cyc;
    start_load(tag);
    send_beats(nbeats, kind, stall, 1'b0, miss);
    m_loaded = 1'b1;
    check({tag, "_ready_held"}, 32'(miss),          32'd0);
    check({tag, "_ready_done"}, 32'(lt_if.ltready), 32'd0);
    check({tag, "_loaded"},     32'(loaded),        32'd1);
    check({tag, "_err"},        32'(err),           32'(exp_err));
    if (!stall) check({tag, "_latency"}, 32'(cyc - c0), 32'(nbeats + 2));
    @(negedge clk);
  endtask

  initial begin
    int miss;
    rst = 1'b1;
    load = 1'b0;
    rd_en = 1'b0;
    rd_addr = '0;
    lt_if.ltdata = '0;
    lt_if.ltvalid = 1'b0;
    lt_if.ltlast = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_start",    32'(lt_if.start),   32'd0);
    check("rst_ready",    32'(lt_if.ltready), 32'd0);
    check("rst_loaded",   32'(loaded),        32'd0);
    check("rst_err",      32'(err),           32'd0);
    check("rst_rd_data",  32'(rd_data),       32'd0);
    check("rst_rd_valid", 32'(rd_valid),      32'd0);

    // Read before any load.
    rd_issue(3);
    rd_end();

    // Nominal transfer with spot reads and an out-of-range read.
    xfer("nom", 160, 0, 1'b0, 1'b0);
    rd_issue(0);
    rd_issue(80);
    rd_issue(159);
    rd_issue(200);
    rd_end();

    // Short stream: entries 100..159 keep the nominal data.
    xfer("short", 100, 1, 1'b0, 1'b1);
    read_all();

    // Stalled stream restores the nominal table.
    xfer("stall", 160, 0, 1'b1, 1'b0);
    read_all();

    // Long stream: excess beats discarded; entry 9 is 0xF6.
    xfer("long", 170, 2, 1'b0, 1'b1);
    read_all();

    // Reset in the middle of a transfer.
    start_load("rstmid");
    send_beats(50, 1, 1'b0, 1'b1, miss);
    check("rstmid_ready_held", 32'(miss), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_ready",  32'(lt_if.ltready), 32'd0);
    check("rstmid_loaded", 32'(loaded),        32'd0);
    check("rstmid_start",  32'(lt_if.start),   32'd0);
    @(negedge clk);
    rd_issue(0);
    rd_end();

    // Full reload, then a second load from DONE.
    xfer("reload", 160, 0, 1'b0, 1'b0);
    xfer("reload2", 160, 2, 1'b0, 1'b0);
    read_all();

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/lut_buffer.md
# lut_buffer

Consumer stage for the LUT byte stream in the rectify fetch path. Requests a LUT transfer from the upstream LUT source with a one-cycle `start` pulse and accepts signed 8-bit entries over a valid/ready/last handshake. Stores the entries in an internal table and checks the stream length against `DEPTH`. Once loaded, it serves random-access reads to the rectify datapath with one-cycle latency.

## Interface
- `DEPTH`, 160: number of LUT entries expected per transfer.
- `AW`, 8: address width; must satisfy 2^AW >= DEPTH.
- `DW`, 8: entry width; entries are two's-complement signed.

- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  request a (re)load; sampled only in IDLE and DONE.
- `start`  out  1  one-cycle pulse to the upstream source to begin streaming.
- `ltdata`  in  DW  stream entry.
- `ltvalid`  in  1  stream valid.
- `ltlast`  in  1  marks the final entry of the stream.
- `ltready`  out  1  stream ready; high only in LOAD.
- `loaded`  out  1  table holds a complete transfer.
- `err`  out  1  the last transfer's length was not equal to DEPTH; sticky until the next `load` or `rst`.
- `rd_en`  in  1  read request.
- `rd_addr`  in  AW  read address.
- `rd_data`  out  DW  read data, registered.
- `rd_valid`  out  1  `rd_en` delayed by one cycle.

## Operation
- States: IDLE, REQ, LOAD, DONE. `ltready` = (state == LOAD) and is decoded from the state register only, with no input-to-output combinational path.
- IDLE: `load` -> REQ; also clears `err` and `loaded` and sets `wr_cnt` to 0.
- REQ: `start` = 1 for exactly this cycle -> LOAD.
- LOAD: a beat is a cycle with `ltvalid && ltready`. Each beat:
  - if `wr_cnt` < DEPTH, write `mem[wr_cnt]` <= `ltdata`;
  - `wr_cnt` increments and saturates at DEPTH.
- LOAD, beat with `ltlast` = 1:
  - go to DONE and set `loaded` = 1;
  - set `err` = 1 if that beat's index != DEPTH-1 (short or long stream).
- Overflow: beats at index >= DEPTH are accepted and discarded, and `ltready` stays high until `ltlast`. `err` is set at the last beat.
- DONE: `loaded` = 1. `load` -> REQ, clearing `loaded`, `err` and `wr_cnt`.
- `load` is ignored in REQ and LOAD.
- Reads are accepted in every state. On `rd_en`, next cycle:
  - `rd_data` = `mem[rd_addr]` if `loaded` = 1 and `rd_addr` < DEPTH, else 0;
  - `rd_valid` = 1.
- Read and write to the same address in the same cycle: the read returns 0, because `loaded` = 0 throughout LOAD.
- `mem` is not reset. Its contents survive `rst` and a re-`load` until they are overwritten.

## Timing
- Reset values: state IDLE, `start` 0, `ltready` 0, `loaded` 0, `err` 0, `rd_data` 0, `rd_valid` 0, `wr_cnt` 0.
- `load` high in IDLE at edge N gives `start` = 1 in cycle N+1 and `ltready` = 1 from cycle N+2.
- Last beat at edge M gives `ltready` = 0, `loaded` = 1 and `err` valid from cycle M+1.
- A full DEPTH-entry transfer with no stalls takes DEPTH+2 cycles from `load` to `loaded`.
- `ltvalid` gaps stall the transfer with no penalty; no beat is lost or duplicated.
- Read latency is 1 cycle. One read per cycle sustained, with back-to-back `rd_en` allowed.
- `rst` mid-LOAD: returns to IDLE on the next edge with `ltready` = 0 and `loaded` = 0. The upstream source is reset by the same `rst`.

## Test plan
- Nominal transfer:
  - stimulus: `load` pulse, then 160 beats 0x00..0x9F with `ltlast` on beat 159;
  - response: one `start` pulse, `loaded` = 1 and `err` = 0 one cycle after beat 159;
  - readback: `rd_addr` 0, 80, 159 return 0x00, 0x50, 0x9F with `rd_valid` one cycle after `rd_en`.
- Stalls: same stream with `ltvalid` low on every third cycle -> identical table contents and no extra `wr_cnt` increments; readback of all 160 entries matches.
- Short stream: `ltlast` on beat 99 -> `loaded` = 1, `err` = 1, entries 0..99 written, entries 100..159 keep their prior values.
- Long stream: 170 beats with `ltlast` on beat 169 -> `ltready` held for all 170 beats, `err` = 1, `mem[159]` = beat 159 data, no write beyond index 159.
- Read edge cases:
  - `rd_en` before any load returns 0 with `rd_valid` = 1;
  - `rd_addr` = 200 after a load returns 0;
  - a signed entry 0xF6 reads back as 0xF6.
- Reset and re-load:
  - `rst` asserted at beat 50 -> next cycle state IDLE, `ltready` = 0, `loaded` = 0;
  - then `load` with a full 160-beat stream -> `loaded` = 1, `err` = 0, and a second `load` in DONE clears `loaded` before the new transfer.
